top_memory: RTL
===============

Name: top_memory

Overview:
- Memory stage of the 5-stage RV32I pipeline, between the EX/MEM register and the writeback result mux.
- Performs load/store to data memory over a req/ready handshake. Generates byte enables and load sign/zero extension.
- Contains the MEM/WB pipeline register and drives the W-stage signals consumed by writeback.
- Stalls the pipeline while memory is busy; aborts an access after a bounded timeout.

Parameters:
- WIDTH, 32, datapath and address width.
- TIMEOUT, 15, maximum wait-state count before an access is aborted (1..255).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ALUResult_M  in  WIDTH  effective address / ALU result
- writeData_M  in  WIDTH  store data (rs2)
- PCPlus4_M  in  WIDTH  PC+4
- rd_M  in  5  destination register
- regWrite_M  in  1  register write enable
- memWrite_M  in  1  store
- resultSrc_M  in  2  00 ALU, 01 load, 10 PC+4
- funct3_M  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- mem_req  out  1  access request
- mem_we  out  1  write
- mem_addr  out  WIDTH  word address {ALUResult_M[WIDTH-1:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  WIDTH  lane-shifted store data
- mem_rdata  in  WIDTH  read word
- mem_ready  in  1  access complete this cycle
- stall_M  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- misalign_M  out  1  one-cycle pulse, misaligned access suppressed
- timeout_M  out  1  one-cycle pulse, access aborted
- ALUResult_W, readData_W, PCPlus4_W  out  WIDTH  registered W-stage values
- rd_W  out  5; regWrite_W  out  1; resultSrc_W  out  2

Behaviour:
- Access conditions:
  - access = memWrite_M | (resultSrc_M==01).
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=00.
  - Misaligned access: no mem_req, misalign_M=1 combinationally. W register loads the instruction with regWrite_W forced 0. No stall.
- Byte enables:
  - B: 0001<<addr[1:0].
  - H: 0011<<addr[1:0].
  - W: 1111.
  - mem_wdata replicates the byte/half across lanes.
- Load extract: select lane by addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passes through.
- FSM states IDLE, WAIT:
  - IDLE, aligned access:
    - mem_req=1 combinationally.
    - If mem_ready: complete with zero wait states. W register captures at the next edge; stall_M=0.
    - Else: stall_M=1, wait counter := 1, next state WAIT.
  - WAIT:
    - mem_req=1; mem_addr/be/wdata are stable because EX/MEM is held by stall_M.
    - If mem_ready: stall_M=0, capture into W, next state IDLE.
    - Else if counter==TIMEOUT: abort with mem_req=0, timeout_M=1, stall_M=0. W captures with regWrite_W=0, then IDLE.
    - Otherwise: counter+1, stall_M=1.
- MEM/WB register:
  - Every cycle with stall_M=1, W loads a bubble: regWrite_W=0, rd_W=0, resultSrc_W=00, data fields 0.
  - Otherwise W loads the M inputs. readData_W is the extended load data, or 0 for non-loads.
- Reset:
  - All W outputs = 0, state IDLE, counter 0.
  - Reset asserted mid-WAIT: mem_req, stall_M, misalign_M and timeout_M drop immediately; no capture occurs.
- Simultaneous events:
  - mem_ready in the same cycle the counter reaches TIMEOUT: completion wins.
  - Non-access instructions never stall.

Decomposition:
- Package riscv_pkg:
  - mem_state_t enum (IDLE, WAIT).
  - funct3 load/store constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - resultSrc constants (RES_ALU=00, RES_MEM=01, RES_PC4=10).
- One sub-module: load_store_unit.
  - Purely combinational: byte enables, store lane shift, misalign detect, load extract/extend.
  - top_memory holds the FSM, counter and pipeline register.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, mem_ready tied 1 -> mem_be=1111, mem_we=1, stall_M never asserted, regWrite_W=0 the next cycle.
- LB addr 0x103, mem_rdata 0x80AABBCC, 2 wait states -> stall_M high 2 cycles, W bubbles during stall, then readData_W=0xFFFFFF80, resultSrc_W=01.
- LHU addr 0x102, rdata 0x8001xxxx, zero wait -> readData_W=0x00008001. SB addr 0x101 data 0x55 -> mem_be=0010, mem_wdata=0x55555555.
- LW addr 0x102 -> misalign_M pulses, mem_req stays 0, regWrite_W=0, no stall.
- LW with mem_ready held 0, TIMEOUT=15 -> stall_M for 15 cycles, timeout_M pulse, regWrite_W=0, FSM back to IDLE. A second load with ready=1 then completes normally.
- rst asserted in the 2nd WAIT cycle -> mem_req and stall_M fall asynchronously and all W outputs are 0. After release, an ALU instruction (resultSrc 00, ALUResult 0x42) appears at ALUResult_W one cycle later.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and encodings for the RV32I memory stage.
// Holds the memory FSM states, load/store size codes and result-source selects.
package riscv_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/load_store_unit.sv
// Combinational lane logic: byte enables, store replication, misalign detect, load extract/extend.
// Zero latency; no state and no flow control of its own.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       addr_i,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [WIDTH-1:0] rdata_i,
    output logic [3:0]       be_o,
    output logic [WIDTH-1:0] wdata_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic             misalign_o
);

    logic [WIDTH-1:0] shifted;

    always_comb begin
        // Bring the addressed lane down to bit 0; word accesses are aligned so this is a no-op for them.
        shifted    = rdata_i >> {addr_i, 3'b000};
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        rdata_o    = shifted;
        misalign_o = 1'b0;
        case (funct3_i)
            F3_B, F3_BU: begin
                be_o    = 4'b0001 << addr_i;
                wdata_o = {(WIDTH/8){wdata_i[7:0]}};
                rdata_o = (funct3_i == F3_B) ? {{(WIDTH-8){shifted[7]}}, shifted[7:0]}
                                             : {{(WIDTH-8){1'b0}}, shifted[7:0]};
            end
            F3_H, F3_HU: begin
                be_o       = 4'b0011 << addr_i;
                wdata_o    = {(WIDTH/16){wdata_i[15:0]}};
                rdata_o    = (funct3_i == F3_H) ? {{(WIDTH-16){shifted[15]}}, shifted[15:0]}
                                                : {{(WIDTH-16){1'b0}}, shifted[15:0]};
                misalign_o = addr_i[0];
            end
            F3_W: begin
                misalign_o = (addr_i != 2'b00);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/top_memory.sv
// RV32I memory stage: req/ready data-memory access with wait-state stall and timeout, plus MEM/WB register.
// W updates one cycle after completion; stall_M holds upstream while memory is busy, bubbles fill W meanwhile.
module top_memory
    import riscv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ALUResult_M,
    input  logic [WIDTH-1:0] writeData_M,
    input  logic [WIDTH-1:0] PCPlus4_M,
    input  logic [4:0]       rd_M,
    input  logic             regWrite_M,
    input  logic             memWrite_M,
    input  logic [1:0]       resultSrc_M,
    input  logic [2:0]       funct3_M,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic             stall_M,
    output logic             misalign_M,
    output logic             timeout_M,
    output logic [WIDTH-1:0] ALUResult_W,
    output logic [WIDTH-1:0] readData_W,
    output logic [WIDTH-1:0] PCPlus4_W,
    output logic [4:0]       rd_W,
    output logic             regWrite_W,
    output logic [1:0]       resultSrc_W
);

    mem_state_t       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_q, rdata_q, pc4_q;
    logic [4:0]       rd_q;
    logic             regwrite_q;
    logic [1:0]       ressrc_q;

    logic             is_load, access, misaligned, kill;
    logic [WIDTH-1:0] load_data;

    assign is_load  = (resultSrc_M == RES_MEM);
    assign access   = memWrite_M | is_load;
    assign mem_addr = {ALUResult_M[WIDTH-1:2], 2'b00};
    assign mem_we   = mem_req & memWrite_M;

    load_store_unit #(.WIDTH(WIDTH)) u_lsu (
        .addr_i     (ALUResult_M[1:0]),
        .funct3_i   (funct3_M),
        .wdata_i    (writeData_M),
        .rdata_i    (mem_rdata),
        .be_o       (mem_be),
        .wdata_o    (mem_wdata),
        .rdata_o    (load_data),
        .misalign_o (misaligned)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_req    = 1'b0;
        stall_M    = 1'b0;
        misalign_M = 1'b0;
        timeout_M  = 1'b0;
        // Gating on rst makes the handshake outputs drop as soon as reset asserts, not at the next edge.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (access && misaligned) begin
                        misalign_M = 1'b1;
                    end else if (access) begin
                        mem_req = 1'b1;
                        if (!mem_ready) begin
                            stall_M = 1'b1;
                            cnt_d   = 8'd1;
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        cnt_d   = 8'd0;
                        state_d = IDLE;
                    end else if (cnt_q == 8'(TIMEOUT)) begin
                        mem_req   = 1'b0;
                        timeout_M = 1'b1;
                        cnt_d     = 8'd0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        stall_M = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign kill = misalign_M | timeout_M;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || stall_M) begin
            alu_q      <= '0;
            rdata_q    <= '0;
            pc4_q      <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            ressrc_q   <= RES_ALU;
        end else begin
            alu_q      <= ALUResult_M;
            rdata_q    <= (is_load && !kill) ? load_data : '0;
            pc4_q      <= PCPlus4_M;
            rd_q       <= rd_M;
            regwrite_q <= regWrite_M & ~kill;
            ressrc_q   <= resultSrc_M;
        end
    end

    assign ALUResult_W = alu_q;
    assign readData_W  = rdata_q;
    assign PCPlus4_W   = pc4_q;
    assign rd_W        = rd_q;
    assign regWrite_W  = regwrite_q;
    assign resultSrc_W = ressrc_q;

endmodule
